// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the dual-core data-memory arbiter.
// Holds the arbiter FSM encoding, requester id type and requester count.
package dmem_arbiter_pkg;

    localparam int unsigned ARB_NREQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    function automatic logic [ARB_NREQ-1:0] id_onehot(input req_id_t id);
        logic [ARB_NREQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_rr_pick.sv
// Combinational requester pick: round-robin between two requesters.
// With DMEM_ARB_LOCK_EN defined, an active lock restricts the pick to the lock owner.
module arb_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [ARB_NREQ-1:0] req_i,
    input  req_id_t             rr_ptr_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                lock_active_i,
    input  req_id_t             lock_id_i,
`endif
    output logic                valid_o,
    output req_id_t             id_o
);

    always_comb begin
        valid_o = |req_i;
        if (req_i[0] && req_i[1]) begin
            id_o = rr_ptr_i;
        end else begin
            id_o = req_i[1];
        end
`ifdef DMEM_ARB_LOCK_EN
        if (lock_active_i) begin
            valid_o = req_i[lock_id_i];
            id_o    = lock_id_i;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between two core memory stages: round-robin pick,
// fixed MEM_LAT sequencing, per-requester stall. Optional lock: DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ARB_NREQ-1:0]            req,
    input  logic [ARB_NREQ-1:0]            we,
    input  logic [ARB_NREQ-1:0][XLEN-1:0]  addr,
    input  logic [ARB_NREQ-1:0][XLEN-1:0]  wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [ARB_NREQ-1:0]            lock,
`endif
    output logic [ARB_NREQ-1:0]            gnt,
    output logic [ARB_NREQ-1:0]            rvalid,
    output logic [XLEN-1:0]                rdata,
    output logic [ARB_NREQ-1:0]            stall,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [XLEN-1:0]                mem_addr,
    output logic [XLEN-1:0]                mem_wdata,
    input  logic [XLEN-1:0]                mem_rdata
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    arb_state_t      state_q, state_d;
    req_id_t         id_q, id_d;
    req_id_t         rr_ptr_q, rr_ptr_d;
    logic            we_q, we_d;
    logic            first_q, first_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    req_id_t         rr_eff;
    logic            pick_valid;
    req_id_t         pick_id;
    logic            in_access;

`ifdef DMEM_ARB_LOCK_EN
    logic            lock_vld_q, lock_vld_d;
    req_id_t         lock_id_q, lock_id_d;
    logic            lock_active;
    logic            lock_release;

    assign lock_active  = lock_vld_q &  lock[lock_id_q];
    assign lock_release = lock_vld_q & ~lock[lock_id_q];
    // A release in IDLE must already favour the other requester this cycle.
    assign rr_eff       = lock_release ? ~lock_id_q : rr_ptr_q;
`else
    assign rr_eff       = rr_ptr_q;
`endif

    arb_rr_pick u_pick (
        .req_i         (req),
        .rr_ptr_i      (rr_eff),
`ifdef DMEM_ARB_LOCK_EN
        .lock_active_i (lock_active),
        .lock_id_i     (lock_id_q),
`endif
        .valid_o       (pick_valid),
        .id_o          (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = we_q;
        first_d   = first_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
`ifdef DMEM_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (lock_release) begin
            lock_vld_d = 1'b0;
            rr_ptr_d   = ~lock_id_q;
        end
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    id_d      = pick_id;
                    we_d      = we[pick_id];
                    addr_d    = addr[pick_id];
                    wdata_d   = wdata[pick_id];
                    lat_cnt_d = LAT_INIT;
                    first_d   = 1'b1;
                    state_d   = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                first_d = 1'b0;
                if (lat_cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    rr_ptr_d = ~id_q;
`ifdef DMEM_ARB_LOCK_EN
                    if (lock[id_q]) begin
                        lock_vld_d = 1'b1;
                        lock_id_d  = id_q;
                        rr_ptr_d   = rr_ptr_q;
                    end
`endif
                    state_d = ARB_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ARB_RESP: begin
                rdata_d = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            id_q      <= 1'b0;
            rr_ptr_q  <= 1'b0;
            we_q      <= 1'b0;
            first_q   <= 1'b0;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= we_d;
            first_q   <= first_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
`endif
        end
    end

    // Memory-side and response outputs decode straight from state so reset clears them at once.
    assign in_access = (state_q == ARB_ACCESS);
    assign gnt       = (in_access && first_q) ? id_onehot(id_q) : '0;
    assign rvalid    = (state_q == ARB_RESP) ? id_onehot(id_q) : '0;
    assign rdata     = rdata_q;
    assign stall     = req & ~rvalid;
    assign mem_en    = in_access;
    assign mem_we    = in_access & first_q & we_q;
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table on a MEM_LAT=1 instance plus
// hand sequences on a MEM_LAT=3 instance; lock sequence when DMEM_ARB_LOCK_EN is set.
module tb_dmem_arbiter;

    logic clk;
    int   checks;
    int   errors;
    logic mem_init;

    logic              a_rst_n, b_rst_n;
    logic [1:0]        a_req, a_we, a_gnt, a_rvalid, a_stall;
    logic [1:0][31:0]  a_addr, a_wdata;
    logic [31:0]       a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic              a_mem_en, a_mem_we;
    logic [1:0]        b_req, b_we, b_gnt, b_rvalid, b_stall;
    logic [1:0][31:0]  b_addr, b_wdata;
    logic [31:0]       b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic              b_mem_en, b_mem_we;
`ifdef DMEM_ARB_LOCK_EN
    logic [1:0]        a_lock, b_lock;
`endif

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    dmem_arbiter #(.XLEN(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(a_rst_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .lock(a_lock),
`endif
        .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .stall(a_stall),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.XLEN(32), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(b_rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .lock(b_lock),
`endif
        .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .stall(b_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational read, write commits on the clock edge.
    assign a_mem_rdata = mem_a[a_mem_addr[7:2]];
    assign b_mem_rdata = mem_b[b_mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 32'hA000_0000 | i;
                mem_b[i] <= 32'hB000_0000 | i;
            end
            mem_a[4] <= 32'hDEAD_BEEF;
            mem_a[5] <= 32'h1234_5678;
        end else begin
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd0;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [1:0]  stall;
        logic        en;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd0,
                                input logic [1:0] gnt, input logic [1:0] rvalid, input logic [1:0] stall,
                                input logic en, input logic mwe, input logic [31:0] maddr,
                                input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.wd0 = wd0;
        v.gnt = gnt; v.rvalid = rvalid; v.stall = stall; v.en = en; v.mwe = mwe;
        v.maddr = maddr; v.rdata = rdata;
        return v;
    endfunction

`ifdef DMEM_ARB_LOCK_EN
    task automatic run_lock_test();
        int served, early, rv_cyc, g1_cyc;
        logic saw_g0;
        served = 0; early = 0; rv_cyc = -1; g1_cyc = -1; saw_g0 = 1'b0;
        @(posedge clk); #1;
        a_req = 2'b01; a_we = '0; a_addr[0] = 32'h10; a_addr[1] = 32'h14; a_lock = 2'b01;
        for (int c = 0; c < 40 && g1_cyc < 0; c++) begin
            @(negedge clk);
            if (a_gnt[0]) saw_g0 = 1'b1;
            if (a_gnt[1]) begin
                if (served < 3) early++;
                else g1_cyc = c;
            end
            if (a_rvalid[0]) begin
                served++;
                if (served == 3) rv_cyc = c;
            end
            @(posedge clk); #1;
            if (saw_g0) a_req[1] = 1'b1;
            if (served >= 3) a_lock = 2'b00;
        end
        chk("lock.early_gnt1", 32'(early), 32'd0);
        chk("lock.served0", 32'(served), 32'd3);
        chk("lock.gnt1_latency", 32'(g1_cyc - rv_cyc), 32'd2);
        a_req = '0;
        repeat (4) @(posedge clk);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        int we_cnt, lat, gnt_cyc, rv_seen;
        logic got;
        logic [31:0] rd;
        checks = 0; errors = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0; mem_init = 1'b1;
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
        a_lock = '0; b_lock = '0;
`endif
        repeat (3) @(posedge clk);
        #1 a_req = 2'b01;
        @(negedge clk);
        chk("rst.stall_follows_req", 32'(a_stall), 32'h1);
        chk("rst.gnt", 32'(a_gnt), 32'h0);
        chk("rst.rvalid", 32'(a_rvalid), 32'h0);
        chk("rst.mem_en", 32'(a_mem_en), 32'h0);
        chk("rst.rdata", a_rdata, 32'h0);
        a_req = '0;
        a_rst_n = 1'b1; b_rst_n = 1'b1; mem_init = 1'b0;

        // Both held (rr 0,1,0,1), single read, then a write whose req drops early.
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b11, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b01, 2'b00, 2'b11, 1, 0, 32'h10, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b01, 2'b10, 0, 0, 32'h00, 32'hDEADBEEF));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b11, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b10, 2'b00, 2'b11, 1, 0, 32'h14, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b10, 2'b01, 0, 0, 32'h00, 32'h12345678));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b11, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b01, 2'b00, 2'b11, 1, 0, 32'h10, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b01, 2'b10, 0, 0, 32'h00, 32'hDEADBEEF));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b11, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b10, 2'b00, 2'b11, 1, 0, 32'h14, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b10, 2'b01, 0, 0, 32'h00, 32'h12345678));
        vecs.push_back(mk(2'b00, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b01, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h10, 32'h14, 32'h0, 2'b01, 2'b00, 2'b01, 1, 0, 32'h10, 32'h0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b01, 2'b00, 0, 0, 32'h00, 32'hDEADBEEF));
        vecs.push_back(mk(2'b00, 2'b00, 32'h10, 32'h14, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b01, 2'b01, 32'h18, 32'h14, 32'hCAFEF00D, 2'b00, 2'b00, 2'b01, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b01, 2'b01, 32'h18, 32'h14, 32'hCAFEF00D, 2'b01, 2'b00, 2'b01, 1, 1, 32'h18, 32'h0));
        vecs.push_back(mk(2'b00, 2'b01, 32'h18, 32'h14, 32'hCAFEF00D, 2'b00, 2'b01, 2'b00, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h18, 32'h14, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0, 32'h00, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            a_req = vecs[i].req; a_we = vecs[i].we;
            a_addr[0] = vecs[i].a0; a_addr[1] = vecs[i].a1; a_wdata[0] = vecs[i].wd0;
            @(negedge clk);
            chk($sformatf("v%0d.gnt", i), 32'(a_gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d.rvalid", i), 32'(a_rvalid), 32'(vecs[i].rvalid));
            chk($sformatf("v%0d.stall", i), 32'(a_stall), 32'(vecs[i].stall));
            chk($sformatf("v%0d.mem_en", i), 32'(a_mem_en), 32'(vecs[i].en));
            chk($sformatf("v%0d.mem_we", i), 32'(a_mem_we), 32'(vecs[i].mwe));
            chk($sformatf("v%0d.mem_addr", i), a_mem_addr, vecs[i].maddr);
            chk($sformatf("v%0d.rdata", i), a_rdata, vecs[i].rdata);
        end
        chk("a.write_committed", mem_a[6], 32'hCAFEF00D);

`ifdef DMEM_ARB_LOCK_EN
        run_lock_test();
`endif

        // MEM_LAT=3: core1 write 0x55 to 0x20, then core0 reads it back.
        @(posedge clk); #1;
        b_req = 2'b10; b_we = 2'b10; b_addr[1] = 32'h20; b_wdata[1] = 32'h55;
        we_cnt = 0; got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (b_mem_we) we_cnt++;
            if (b_rvalid[1]) got = 1'b1;
            @(posedge clk); #1;
        end
        b_req = '0; b_we = '0;
        chk("b.write_rvalid", 32'(got), 32'h1);
        chk("b.mem_we_cycles", 32'(we_cnt), 32'd1);
        b_req = 2'b01; b_addr[0] = 32'h20;
        lat = -1; gnt_cyc = -1; rd = '0;
        for (int c = 0; c < 12 && lat < 0; c++) begin
            @(negedge clk);
            if (b_gnt[0]) gnt_cyc = c;
            if (b_rvalid[0]) begin
                lat = c;
                rd  = b_rdata;
            end
            @(posedge clk); #1;
        end
        b_req = '0;
        chk("b.read_gnt_cycle", 32'(gnt_cyc), 32'd1);
        chk("b.read_rvalid_cycle", 32'(lat), 32'd4);
        chk("b.read_rdata", rd, 32'h55);

        // Reset during the second ACCESS cycle of a read.
        @(posedge clk); #1;
        b_req = 2'b01; b_addr[0] = 32'h24;
        @(posedge clk);
        @(posedge clk); #1;
        chk("b.pre_rst_mem_en", 32'(b_mem_en), 32'h1);
        #1 b_rst_n = 1'b0;
        #1;
        chk("b.rst_gnt", 32'(b_gnt), 32'h0);
        chk("b.rst_rvalid", 32'(b_rvalid), 32'h0);
        chk("b.rst_mem_en", 32'(b_mem_en), 32'h0);
        chk("b.rst_mem_we", 32'(b_mem_we), 32'h0);
        chk("b.rst_mem_addr", b_mem_addr, 32'h0);
        chk("b.rst_rdata", b_rdata, 32'h0);
        chk("b.rst_stall", 32'(b_stall), 32'h1);
        rv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (b_rvalid != 2'b00) rv_seen++;
        end
        b_req = '0;
        b_rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (b_rvalid != 2'b00) rv_seen++;
        end
        chk("b.no_rvalid_after_rst", 32'(rv_seen), 32'd0);
        @(posedge clk); #1;
        b_req = 2'b11; b_addr[0] = 32'h10; b_addr[1] = 32'h14;
        @(negedge clk);
        chk("b.post_rst_idle_gnt", 32'(b_gnt), 32'h0);
        @(negedge clk);
        chk("b.post_rst_gnt_rr0", 32'(b_gnt), 32'h1);
        @(posedge clk); #1;
        b_req = '0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
